// File: rtl/aoi_pkg.sv
// aoi_pkg -- shared definitions for the pipelined AND-OR-(INVERT) block.
//
// Holds the default lane width, AND-term count and inversion setting. It also
// holds the reduce function that turns a K*W AND-term vector into the W-bit
// OR (optionally inverted) result. The function works on a fixed maximum-size
// vector, so callers zero-extend their terms and truncate the result to W.
package aoi_pkg;

    localparam int W_DEFAULT   = 4;
    localparam int K_DEFAULT   = 2;
    localparam int INV_DEFAULT = 1;

    // Upper bounds for the reduce helper; W and K must not exceed these.
    localparam int MAX_W     = 64;
    localparam int MAX_K     = 8;
    localparam int MAX_TERMS = MAX_W * MAX_K;
    localparam int IDX_W     = $clog2(MAX_TERMS);

    // Term k of bit i sits at terms[k*w + i]; bits at or above w are left at 0.
    function automatic logic [MAX_W-1:0] aoi_reduce(
        input logic [MAX_TERMS-1:0] terms,
        input int                   w,
        input int                   k,
        input bit                   inv
    );
        logic [MAX_W-1:0] res;
        logic [IDX_W-1:0] idx;
        res = '0;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                for (int j = 0; j < MAX_K; j++) begin
                    if (j < k) begin
                        idx    = IDX_W'(j * w + i);
                        res[i] = res[i] | terms[idx];
                    end
                end
                if (inv) begin
                    res[i] = ~res[i];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aoi_pipe_if.sv
// aoi_pipe_if -- valid/ready operand and result bus of aoi_pipe.
//
//   in_valid / in_ready : operand-set handshake (a, b carry K terms of W bits)
//   a, b                : AND inputs; term k occupies bits [k*W +: W]
//   out_valid/out_ready : result handshake
//   y                   : W-bit registered result
//
// The master modport is the producer/consumer environment. The slave modport
// is the pipeline.
interface aoi_pipe_if
    import aoi_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int K = K_DEFAULT
);

    logic           in_valid;
    logic           in_ready;
    logic [K*W-1:0] a;
    logic [K*W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   y;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/aoi_stage.sv
// aoi_stage -- one valid/ready register slice with asynchronous reset.
//
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_data   : upstream item
//   in_ready            : slice can take an item this cycle
//   out_valid, out_data : registered item
//   out_ready           : downstream takes the item this cycle
//
// The slice loads when it is empty or its item leaves in the same cycle.
// Data only changes on an actual load, so idle inputs leave no trace.
module aoi_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/aoi_pipe.sv
// aoi_pipe -- two-stage pipelined AND-OR-INVERT (or AND-OR) per bit.
//
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aoi_pipe_if slave; operands a/b in, result y out, each side
//              with its own valid/ready handshake
//
// Stage 1 registers the K*W AND terms. Stage 2 registers the OR-reduced,
// optionally inverted W-bit result. The ready signals chain back through the
// slices, so in_ready = !s1_valid | !s2_valid | out_ready.
module aoi_pipe
    import aoi_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int K   = K_DEFAULT,
    parameter int INV = INV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    aoi_pipe_if.slave  bus
);

    logic [K*W-1:0] terms;
    logic           s1_valid;
    logic           s1_ready;
    logic [K*W-1:0] s1_terms;
    logic [W-1:0]   s2_in;

    assign terms = bus.a & bus.b;
    assign s2_in = W'(aoi_reduce(MAX_TERMS'(s1_terms), W, K, INV != 0));

    aoi_stage #(.DW(K*W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (terms),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_terms)
    );

    aoi_stage #(.DW(W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.y)
    );

endmodule

// File: tb/tb_aoi_pipe.sv
// tb_aoi_pipe -- self-checking bench for aoi_pipe.
//
// The main instance uses W=4, K=2, INV=1. A second instance uses W=8, K=3,
// INV=0. Inputs change on the falling edge. Outputs are read 1 ns later,
// well away from the rising edge. A queue of expected results follows every
// accepted operand set and is checked on every output transfer.
module tb_aoi_pipe;

    localparam int W = 4;
    localparam int K = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aoi_pipe_if #(.W(W), .K(K)) bus ();
    aoi_pipe #(.W(W), .K(K), .INV(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    aoi_pipe_if #(.W(8), .K(3)) bus3 ();
    aoi_pipe #(.W(8), .K(3), .INV(0)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] y;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         accepted = 0;
    int         outs = 0;
    logic       last_in_ready;
    logic [3:0] sb[$];
    logic [3:0] y_hold;
    vec_t       vecs[6];

    // Independent model of the K=2, inverted case.
    function automatic logic [3:0] ref_aoi(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = ~((a[i] & b[i]) | (a[4+i] & b[4+i]));
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on the main instance and record both handshakes,
    // checking every output transfer against the expected-result queue.
    task automatic apply_stimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                  input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
        #1;
        last_in_ready = bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            outs++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out: got y=%h with no pending item", bus.y);
            end else begin
                check_output("out_y", 32'(bus.y), 32'(sb.pop_front()));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            accepted++;
            sb.push_back(ref_aoi(a, b));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'h0F, y: 4'h0};
        vecs[1] = '{a: 8'h3C, b: 8'hC3, y: 4'hF};
        vecs[2] = '{a: 8'h00, b: 8'h00, y: 4'hF};
        vecs[3] = '{a: 8'hF0, b: 8'hF0, y: 4'h0};
        vecs[4] = '{a: 8'h12, b: 8'h34, y: 4'hE};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, y: 4'hF};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        bus3.in_valid  = 1'b0;
        bus3.a         = '0;
        bus3.b         = '0;
        bus3.out_ready = 1'b1;

        // Reset state
        #2;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_y", 32'(bus.y), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // W=8, K=3, non-inverting instance
        bus3.in_valid = 1'b1;
        bus3.a = 24'h0000FF;
        bus3.b = 24'h0000AA;
        @(posedge clk); @(negedge clk);
        bus3.in_valid = 1'b1;
        bus3.a = 24'h000000;
        bus3.b = 24'h000000;
        @(posedge clk); @(negedge clk);
        #1;
        check_output("k3_out_valid", 32'(bus3.out_valid), 32'd1);
        check_output("k3_y_aa", 32'(bus3.y), 32'hAA);
        bus3.in_valid = 1'b1;
        bus3.a = 24'h123456;
        bus3.b = 24'hFFFFFF;
        @(posedge clk); @(negedge clk);
        bus3.in_valid = 1'b0;
        #1;
        check_output("k3_y_zero", 32'(bus3.y), 32'h00);
        @(posedge clk); @(negedge clk);
        #1;
        check_output("k3_y_or3", 32'(bus3.y), 32'h76);
        @(posedge clk); @(negedge clk);
        #1;
        check_output("k3_drained", 32'(bus3.out_valid), 32'd0);
        @(negedge clk);

        // Single operations: two-cycle latency and hand-computed results
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, vecs[i].a, vecs[i].b, 1'b1);
            check_output("lat_early", 32'(bus.out_valid), 32'd0);
            apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
            check_output("lat_valid", 32'(bus.out_valid), 32'd1);
            check_output("single_y", 32'(bus.y), 32'(vecs[i].y));
        end
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        check_output("single_drain", 32'(sb.size()), 32'd0);

        // Streaming: 16 back-to-back operand sets
        outs = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1);
        end
        check_output("stream_outs_mid", 32'(outs), 32'd14);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        check_output("stream_outs", 32'(outs), 32'd16);
        check_output("stream_empty", 32'(sb.size()), 32'd0);

        // Backpressure: both stages full, then 5 stalled cycles
        apply_stimulus(1'b1, 8'h3C, 8'hC3, 1'b1);
        apply_stimulus(1'b1, 8'hFF, 8'h0F, 1'b1);
        apply_stimulus(1'b1, 8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 5; i++) begin
            y_hold = bus.y;
            apply_stimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
            check_output("bp_in_ready", 32'(last_in_ready), 32'd0);
            check_output("bp_y_stable", 32'(bus.y), 32'(y_hold));
            check_output("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        end
        check_output("bp_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with two items in flight
        apply_stimulus(1'b1, 8'h3C, 8'hC3, 1'b1);
        apply_stimulus(1'b1, 8'hFF, 8'h0F, 1'b1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_y", 32'(bus.y), 32'd0);
        check_output("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_output("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
            check_output("no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Random valid/ready toggling, 1000 transactions
        accepted = 0;
        outs = 0;
        for (int cyc = 0; cyc < 8000 && accepted < 1000; cyc++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                           1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1);
        end
        check_output("rand_accepted", 32'(accepted), 32'd1000);
        check_output("rand_outs", 32'(outs), 32'd1000);
        check_output("rand_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
